ov7670_config_sequencer: RTL
============================

// Module: ov7670_config_sequencer
// PURPOSE
//  Walks the OV7670 register-configuration ROM from entry 0 and issues each
//  {reg,value} word as one SCCB write via a valid/ready command port. Executes
//  the 16'hFFF0 delay marker and stops at the 16'hFFFF end marker. Sits between
//  the config ROM and the SCCB master; done gates the capture datapath.
// PARAMETERS
//  DELAY_CYCLES    250000  clk cycles waited on FFF0 (10 ms at 25 MHz)
//  TIMEOUT_CYCLES  65535   max clk cycles from command accept to cmd_done
//  LAST_ADDR       255     highest ROM address walked; no wrap past it
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   one-cycle pulse: begin/restart the sequence
//  rom_addr   out  8   ROM address; ROM returns rom_dout 1 clk later
//  rom_dout   in   16  ROM word {reg[15:8], value[7:0]}
//  cmd_valid  out  1   SCCB write request valid
//  cmd_ready  in   1   SCCB master accepts when cmd_valid & cmd_ready
//  cmd_reg    out  8   register address of the write
//  cmd_data   out  8   register value of the write
//  cmd_done   in   1   one-cycle pulse: accepted write finished on the bus
//  busy       out  1   high in every state except IDLE and DONE
//  done       out  1   high (level) in DONE; sequence completed without error
//  error      out  1   sticky: SCCB timeout; cleared by rst or start
// BEHAVIOUR
//  Reset (synchronous): state=IDLE, rom_addr=0, cmd_valid=0, cmd_reg=0,
//   cmd_data=0, busy=0, done=0, error=0, delay/timeout counters=0.
//  States: IDLE, FETCH, ROMWAIT, DECODE, SEND, WAITDONE, DELAY, DONE.
//  IDLE: start -> FETCH with rom_addr=0, error cleared.
//  FETCH: rom_addr held -> ROMWAIT (covers 1-cycle ROM latency) -> DECODE.
//  DECODE samples rom_dout:
//   16'hFFFF -> DONE.
//   16'hFFF0 -> DELAY, counter loaded DELAY_CYCLES-1.
//   else -> SEND; cmd_reg=rom_dout[15:8], cmd_data=rom_dout[7:0], cmd_valid=1.
//  SEND: cmd_valid and payload held stable until cmd_valid&cmd_ready; that
//   cycle cmd_valid drops next edge, timeout counter cleared -> WAITDONE.
//   No timeout in SEND (master may stall indefinitely).
//  WAITDONE: cmd_done -> ADVANCE; counter reaches TIMEOUT_CYCLES -> error=1,
//   cmd_valid=0 -> DONE-with-error (state DONE, done=0, error=1).
//  DELAY: count down to 0 -> ADVANCE. DELAY entries produce no SCCB write.
//  ADVANCE (part of the leaving transition, not a state): if rom_addr==
//   LAST_ADDR -> DONE (end marker implied, no wrap); else rom_addr+1 -> FETCH.
//  Latency per write entry: 3 clk (FETCH,ROMWAIT,DECODE) + handshake + SCCB.
//  DONE: holds outputs; start -> restart from addr 0 (done, error cleared).
//  start in any busy state is ignored. cmd_done outside WAITDONE ignored.
//  cmd_done in the same cycle as timeout reached: cmd_done wins, no error.
//  rst mid-transaction: cmd_valid drops immediately at the reset edge; the
//   SCCB master is reset by the same rst.
//  rom_dout is only sampled in DECODE; content is otherwise don't-care.
// TESTING
//  (bench uses DELAY_CYCLES=8, TIMEOUT_CYCLES=20, ROM model with 1-clk latency)
//  ROM {1280,FFF0,1204,FFFF}, cmd_ready=1, cmd_done 5 clk after accept ->
//   writes (12,80),(12,04) in order; exactly 8 clk idle in DELAY; done=1.
//  cmd_ready low 30 clk during SEND -> cmd_valid/cmd_reg/cmd_data stable,
//   no error; single accept when ready rises.
//  cmd_done never returned -> error=1 exactly 20 clk after accept, done=0,
//   cmd_valid=0; start then reruns from addr 0 with error cleared.
//  ROM with no FFFF (all 1111) -> 256 writes, addr stops at 255, done=1.
//  start pulsed mid-sequence -> ignored; rst at entry 2 in WAITDONE ->
//   all outputs at reset values next clk; later start reruns from entry 0.
//  cmd_done coincident with timeout cycle -> advances, error stays 0.

Source files
------------

// File: rtl/ov7670_config_sequencer.sv
// OV7670 configuration sequencer: walks the register ROM from entry 0 and issues
// each {reg,value} word as one SCCB write; FFF0 inserts a delay, FFFF ends the walk.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, waiting for start
// FETCH     | rom_addr presented to the ROM
// ROMWAIT   | covering the 1-clk ROM read latency
// DECODE    | rom_dout sampled: end marker, delay marker or write entry
// SEND      | cmd_valid held with payload until the SCCB master accepts
// WAITDONE  | write accepted, waiting for cmd_done (bounded by timeout)
// DELAY     | counting down the FFF0 delay, no bus activity
// DONE      | sequence finished (done=1) or aborted on timeout (error=1)

`timescale 1ns/1ps

module ov7670_config_sequencer #(
    parameter int unsigned DELAY_CYCLES   = 250000,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned LAST_ADDR      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_data,
    input  logic        cmd_done,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // Counters only ever hold load values up to N-1.
    localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [DW-1:0] DELAY_LOAD = DW'(DELAY_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    ADDR_LAST  = 8'(LAST_ADDR);
    localparam logic [15:0]   MARK_END   = 16'hFFFF;
    localparam logic [15:0]   MARK_DELAY = 16'hFFF0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ROMWAIT,
        ST_DECODE,
        ST_SEND,
        ST_WAITDONE,
        ST_DELAY,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic          valid_q, valid_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    data_q, data_d;
    logic          error_q, error_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            reg_q   <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
            dcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            error_q <= error_d;
            dcnt_q  <= dcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        reg_d   = reg_q;
        data_d  = data_q;
        error_d = error_q;
        dcnt_d  = dcnt_q;
        tcnt_d  = tcnt_q;
        advance = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                    error_d = 1'b0;
                end
            end
            ST_FETCH:   state_d = ST_ROMWAIT;
            ST_ROMWAIT: state_d = ST_DECODE;
            ST_DECODE: begin
                if (rom_dout == MARK_END) begin
                    state_d = ST_DONE;
                end else if (rom_dout == MARK_DELAY) begin
                    state_d = ST_DELAY;
                    dcnt_d  = DELAY_LOAD;
                end else begin
                    state_d = ST_SEND;
                    reg_d   = rom_dout[15:8];
                    data_d  = rom_dout[7:0];
                    valid_d = 1'b1;
                end
            end
            ST_SEND: begin
                // The master may stall indefinitely here; no timeout until accept.
                if (cmd_ready) begin
                    state_d = ST_WAITDONE;
                    valid_d = 1'b0;
                    tcnt_d  = '0;
                end
            end
            ST_WAITDONE: begin
                // A cmd_done landing on the timeout cycle still counts as success.
                if (cmd_done) begin
                    advance = 1'b1;
                end else if (tcnt_q == TOUT_LAST) begin
                    state_d = ST_DONE;
                    error_d = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_DELAY: begin
                if (dcnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    dcnt_d = dcnt_q - DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Walking off the last ROM address acts as an implied end marker.
        if (advance) begin
            if (addr_q == ADDR_LAST) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_FETCH;
                addr_d  = addr_q + 8'd1;
            end
        end
    end

    always_comb begin
        busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done = (state_q == ST_DONE) && !error_q;
    end

    assign rom_addr  = addr_q;
    assign cmd_valid = valid_q;
    assign cmd_reg   = reg_q;
    assign cmd_data  = data_q;
    assign error     = error_q;

endmodule
